fft_int2fp_sched: RTL
=====================

Name: fft_int2fp_sched

Overview:
- In-order scheduler sharing NUM_UNITS HLS int-to-float converter instances (ap_ctrl_hs) between one input sample stream and one output stream.
- Accepts 32-bit integer samples via valid/ready and dispatches them round-robin to free units.
- Captures each unit's result on ap_done and re-emits results in strict input order via valid/ready.
- Sits between the FFT input formatter and the FFT core, replacing the free-running channel rotator.

Parameters:
- NUM_UNITS, 4, number of converter instances; power of two, 2..8.
- DATA_W, 32, sample width (integer in, IEEE-754 single out).
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- s_axi_aclk, input, 1, sole clock.
- s_axi_areset, input, 1, synchronous active-high reset.
- in_data, input, DATA_W, integer sample.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, scheduler accepts in_data this cycle.
- out_data, output, DATA_W, float result.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, downstream accepts.
- ap_start, output, NUM_UNITS, per-unit start request.
- ap_ready, input, NUM_UNITS, per-unit input consumed.
- ap_done, input, NUM_UNITS, per-unit one-cycle result strobe.
- input_r, output, NUM_UNITS*DATA_W, packed operands; unit i is bits [i*DATA_W +: DATA_W].
- output_r, input, NUM_UNITS*DATA_W, packed unit results; sampled only when that unit's ap_done is high.
- in_flight, output, clog2(NUM_UNITS)+1, number of units not IDLE.
- err_timeout, output, NUM_UNITS, sticky per-unit watchdog flag.

Behaviour:
- Interface: one clock (s_axi_aclk); reset s_axi_areset is synchronous and active-high.
- Reset values: all units IDLE; wr_ptr=0, rd_ptr=0; ap_start=0; input_r=0; result registers=0; out_valid=0; in_flight=0; err_timeout=0.
- Per-unit FSM states: IDLE, START, BUSY, DONE.
  - IDLE -> START on input accept when wr_ptr==i.
  - START drives ap_start[i]=1 (registered). ap_start stays high until ap_ready[i] is sampled high.
  - START -> BUSY on ap_ready[i]. If ap_ready[i] and ap_done[i] are high in the same cycle, go START -> DONE and capture output_r.
  - BUSY -> DONE on ap_done[i]; output_r slice is captured into result[i].
  - DONE -> IDLE on output handshake when rd_ptr==i.
  - ap_done[i] in IDLE or DONE is ignored, e.g. stale completions after reset.
- Input side:
  - in_ready = (state[wr_ptr]==IDLE), combinational from state only.
  - On in_valid & in_ready: input_r[wr_ptr] <= in_data; wr_ptr advances modulo NUM_UNITS.
  - input_r[i] is held stable from accept until the unit leaves START.
- Output side:
  - out_valid = (state[rd_ptr]==DONE); out_data = result[rd_ptr].
  - On out_valid & out_ready: rd_ptr advances modulo NUM_UNITS.
  - out_data is held stable while out_valid & ~out_ready.
- Ordering: results always leave in acceptance order, even if units complete out of order. A later-finishing unit stalls delivery of already-DONE successors.
- Full condition: all units non-IDLE, so in_ready=0. When rd_ptr==wr_ptr and that unit is DONE, a same-cycle output handshake does not enable input; in_ready rises the following cycle (no bypass).
- Empty condition: in_flight=0, out_valid=0.
- Latency:
  - Accept at cycle 0 -> ap_start high at cycle 1.
  - ap_done at cycle D -> out_valid at cycle D+1.
  - Minimum total latency is 2 cycles for a zero-latency unit (ap_ready=ap_done=1 at cycle 1).
- in_flight is registered: it increments on accept, decrements on output handshake, and is unchanged when both occur in the same cycle.
- Reset mid-operation: everything returns to reset values in the next cycle and in-progress results are discarded. Late ap_done pulses are ignored per the IDLE rule.

Optional Feature:
- Macro: FFT_INT2FP_TIMEOUT_EN.
- Defined:
  - Each unit has a cycle counter that resets on entering START and counts while the unit is in START or BUSY.
  - When the counter reaches TIMEOUT_CYC, err_timeout[i] sets and stays set until reset. The counter saturates.
  - The flag is report-only: FSM behaviour is unchanged.
- Undefined: no counters are built; err_timeout is tied to 0.

Test Plan:
- Single sample: in_data=0x00000005 with units responding ap_ready at +1 and ap_done at +3 (output_r=0x40A00000) -> out_data=0x40A00000 with out_valid 4 cycles after accept; in_flight returns to 0.
- Burst of 8 samples 1..8 with out_ready=1 and fixed 3-cycle unit latency -> outputs are float(1)..float(8) in order; in_ready drops to 0 after 4 accepts until the first retire.
- Out-of-order completion: unit1 done before unit0 -> no output until unit0 done, then unit0 result followed by unit1 result on consecutive cycles.
- Backpressure: out_ready=0 for 20 cycles with 4 samples in flight -> in_ready=0, out_data stable, in_flight=4; release -> 4 outputs on consecutive cycles.
- ap_start hold: ap_ready withheld 5 cycles -> ap_start and input_r remain stable for 5 cycles; same-cycle ap_ready+ap_done goes straight to DONE.
- Reset mid-burst with 3 units BUSY, then stray ap_done pulses -> out_valid stays 0, in_flight=0; with FFT_INT2FP_TIMEOUT_EN and TIMEOUT_CYC=16, a unit never asserting ap_done sets err_timeout[i] after 16 cycles.

Source files
------------

// File: rtl/fft_int2fp_sched.sv
// fft_int2fp_sched: in-order scheduler that shares NUM_UNITS ap_ctrl_hs
// int-to-float converters between one input stream and one output stream.
// Optional build macro FFT_INT2FP_TIMEOUT_EN adds per-unit watchdog flags.
module fft_int2fp_sched #(
  parameter int unsigned NUM_UNITS   = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_areset,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_UNITS-1:0]          ap_start,
  input  logic [NUM_UNITS-1:0]          ap_ready,
  input  logic [NUM_UNITS-1:0]          ap_done,
  output logic [NUM_UNITS*DATA_W-1:0]   input_r,
  input  logic [NUM_UNITS*DATA_W-1:0]   output_r,
  output logic [$clog2(NUM_UNITS):0]    in_flight,
  output logic [NUM_UNITS-1:0]          err_timeout
);

  localparam int unsigned PTR_W = $clog2(NUM_UNITS);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_BUSY, ST_DONE} unit_state_e;

  // Elaboration-time parameter sanity checks
  if (NUM_UNITS < 2 || NUM_UNITS > 8 || (NUM_UNITS & (NUM_UNITS - 1)) != 0) begin : g_bad_units
    $error("NUM_UNITS must be a power of two in 2..8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  unit_state_e       state_q  [NUM_UNITS];
  unit_state_e       state_d  [NUM_UNITS];
  logic [DATA_W-1:0] opnd_q   [NUM_UNITS];
  logic [DATA_W-1:0] opnd_d   [NUM_UNITS];
  logic [DATA_W-1:0] result_q [NUM_UNITS];
  logic [DATA_W-1:0] result_d [NUM_UNITS];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  in_flight_q, in_flight_d;
  logic              in_fire_c, out_fire_c;

  // Stream handshakes decode only registered unit state (no full-to-empty bypass)
  assign in_ready   = (state_q[wr_ptr_q] == ST_IDLE);
  assign out_valid  = (state_q[rd_ptr_q] == ST_DONE);
  assign out_data   = result_q[rd_ptr_q];
  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = out_valid & out_ready;
  assign in_flight  = in_flight_q;

  // Per-unit start requests and operand buses
  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit_io
    assign ap_start[g]                   = (state_q[g] == ST_START);
    assign input_r[g*DATA_W +: DATA_W]   = opnd_q[g];
  end

  // Next-state logic for unit FSMs, pointers and occupancy
  always_comb begin
    state_d     = state_q;
    opnd_d      = opnd_q;
    result_d    = result_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    in_flight_d = in_flight_q;

    for (int i = 0; i < NUM_UNITS; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (in_fire_c && (wr_ptr_q == PTR_W'(i))) begin
            state_d[i] = ST_START;
            opnd_d[i]  = in_data;
          end
        end
        ST_START: begin
          if (ap_ready[i]) begin
            if (ap_done[i]) begin
              state_d[i]  = ST_DONE;
              result_d[i] = output_r[i*DATA_W +: DATA_W];
            end else begin
              state_d[i]  = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (ap_done[i]) begin
            state_d[i]  = ST_DONE;
            result_d[i] = output_r[i*DATA_W +: DATA_W];
          end
        end
        ST_DONE: begin
          if (out_fire_c && (rd_ptr_q == PTR_W'(i))) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end

    if (in_fire_c)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (out_fire_c) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({in_fire_c, out_fire_c})
      2'b10:   in_flight_d = in_flight_q + 1'b1;
      2'b01:   in_flight_d = in_flight_q - 1'b1;
      default: in_flight_d = in_flight_q;
    endcase
  end

  // State registers with synchronous reset; in-progress results are discarded
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        state_q[i]  <= ST_IDLE;
        opnd_q[i]   <= '0;
        result_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_flight_q <= '0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      result_q    <= result_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_flight_q <= in_flight_d;
    end
  end

`ifdef FFT_INT2FP_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0]     tmr_q [NUM_UNITS];
  logic [TMR_W-1:0]     tmr_d [NUM_UNITS];
  logic [NUM_UNITS-1:0] err_q, err_d;

  // Watchdog: restart on entry to START, saturating count while START/BUSY
  always_comb begin
    tmr_d = tmr_q;
    err_d = err_q;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if ((state_q[i] == ST_IDLE) && (state_d[i] == ST_START)) begin
        tmr_d[i] = '0;
      end else if (((state_q[i] == ST_START) || (state_q[i] == ST_BUSY)) &&
                   (tmr_q[i] != TMR_W'(TIMEOUT_CYC))) begin
        tmr_d[i] = tmr_q[i] + 1'b1;
      end
      if (tmr_q[i] == TMR_W'(TIMEOUT_CYC)) err_d[i] = 1'b1;
    end
  end

  // Watchdog registers; flags are sticky until reset
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      for (int i = 0; i < NUM_UNITS; i++) tmr_q[i] <= '0;
      err_q <= '0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = '0;
`endif

endmodule
